// File: rtl/sbox_share_sched_pkg.sv
// Shared types and helpers for the time-multiplexed S4 column scheduler.
// Holds FSM/tag encodings, column geometry and the AES S-box function.
package sbox_share_sched_pkg;

  localparam int         NCOL     = 4;
  localparam int         COL_W    = 32;
  localparam logic [1:0] LAST_COL = 2'(NCOL - 1);

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_DATA_ISSUE = 2'd1,
    ST_KEY_ISSUE  = 2'd2
  } state_e;

  typedef enum logic {
    TAG_DATA = 1'b0,
    TAG_KEY  = 1'b1
  } tag_type_e;

  typedef struct packed {
    logic      vld;
    tag_type_e typ;
    logic [1:0] col;
  } tag_t;

  // col0 occupies the top word of the 128-bit state, so it is packed slot NCOL-1.
  function automatic logic [1:0] col_slot(input logic [1:0] col);
    return LAST_COL - col;
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse as a^254 (0 maps to 0), followed by the AES affine transform.
  function automatic logic [7:0] sbox_byte(input logic [7:0] a);
    logic [7:0] t;
    logic [7:0] inv;
    t   = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      t   = gf_mul(t, t);
      inv = gf_mul(inv, t);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sbox_word(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sbox_byte(w[8*i +: 8]);
    return r;
  endfunction

endpackage

// File: rtl/sbox_share_sched_if.sv
// Request/response bundle between the scheduler and its two requesters.
interface sbox_share_sched_if;
  logic         data_in_valid;
  logic         data_in_ready;
  logic [127:0] data_in;
  logic         data_out_valid;
  logic         data_out_ready;
  logic [127:0] data_out;
  logic         key_in_valid;
  logic         key_in_ready;
  logic [31:0]  key_in;
  logic         key_out_valid;
  logic         key_out_ready;
  logic [31:0]  key_out;
  logic         busy;

  modport slave (
    input  data_in_valid, data_in, data_out_ready, key_in_valid, key_in, key_out_ready,
    output data_in_ready, data_out_valid, data_out, key_in_ready, key_out_valid, key_out, busy
  );

  modport master (
    output data_in_valid, data_in, data_out_ready, key_in_valid, key_in, key_out_ready,
    input  data_in_ready, data_out_valid, data_out, key_in_ready, key_out_valid, key_out, busy
  );
endinterface

// File: rtl/sbox_share_sched_s4.sv
// Single 32-bit S-box column: four byte S-boxes, SBOX_LAT register stages deep.
module sbox_share_sched_s4
  import sbox_share_sched_pkg::*;
#(
  parameter int SBOX_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] din_i,
  output logic [31:0] dout_o
);
  logic [SBOX_LAT-1:0][31:0] stg_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_q <= '0;
    end else begin
      stg_q[0] <= sbox_word(din_i);
      for (int i = 1; i < SBOX_LAT; i++) stg_q[i] <= stg_q[i-1];
    end
  end

  assign dout_o = stg_q[SBOX_LAT-1];
endmodule

// File: rtl/sbox_share_sched.sv
// Shares one S4 column between 4-beat SubBytes jobs and 1-beat SubWord jobs,
// arbitrating round-robin at job boundaries and tracking beats with a tag pipe.
module sbox_share_sched
  import sbox_share_sched_pkg::*;
#(
  parameter int SBOX_LAT = 1
) (
  input logic               clk,
  input logic               rst,
  sbox_share_sched_if.slave bus
);
  state_e                     state_q, state_d;
  logic [1:0]                 col_q, col_d;
  tag_type_e                  last_grant_q, last_grant_d;
  logic [NCOL-1:0][COL_W-1:0] data_hold_q, data_out_q;
  logic [COL_W-1:0]           key_hold_q, key_out_q, s4_in_q, s4_in_d, s4_out;
  logic                       data_out_valid_q, key_out_valid_q;
  tag_t                       iss_d, iss_q, tail;
  tag_t [SBOX_LAT-1:0]        tag_pipe_q;
  logic                       last_issue, data_inflight, key_inflight, pipe_busy;
  logic                       can_data, can_key, data_rdy, key_rdy, data_hs, key_hs;

  sbox_share_sched_s4 #(.SBOX_LAT(SBOX_LAT)) u_s4 (
    .clk(clk), .rst(rst), .din_i(s4_in_q), .dout_o(s4_out)
  );

  always_comb begin
    iss_d   = '0;
    s4_in_d = '0;
    case (state_q)
      ST_DATA_ISSUE: begin
        iss_d   = '{vld: 1'b1, typ: TAG_DATA, col: col_q};
        s4_in_d = data_hold_q[col_slot(col_q)];
      end
      ST_KEY_ISSUE: begin
        iss_d   = '{vld: 1'b1, typ: TAG_KEY, col: 2'd0};
        s4_in_d = key_hold_q;
      end
      default: ;
    endcase
  end

  // The beat being issued this cycle counts as in flight, which keeps a
  // result from landing on the same edge its predecessor is consumed.
  always_comb begin
    data_inflight = (iss_d.vld && iss_d.typ == TAG_DATA) || (iss_q.vld && iss_q.typ == TAG_DATA);
    key_inflight  = (iss_d.vld && iss_d.typ == TAG_KEY)  || (iss_q.vld && iss_q.typ == TAG_KEY);
    pipe_busy     = iss_q.vld;
    for (int i = 0; i < SBOX_LAT; i++) begin
      data_inflight = data_inflight || (tag_pipe_q[i].vld && tag_pipe_q[i].typ == TAG_DATA);
      key_inflight  = key_inflight  || (tag_pipe_q[i].vld && tag_pipe_q[i].typ == TAG_KEY);
      pipe_busy     = pipe_busy || tag_pipe_q[i].vld;
    end
  end

  assign last_issue = (state_q == ST_DATA_ISSUE && col_q == LAST_COL) || state_q == ST_KEY_ISSUE;
  assign can_data   = (state_q == ST_IDLE || last_issue) && !data_out_valid_q && !data_inflight;
  assign can_key    = (state_q == ST_IDLE || last_issue) && !key_out_valid_q && !key_inflight;
  assign data_rdy   = !rst && can_data && !(bus.key_in_valid && can_key && last_grant_q == TAG_DATA);
  assign key_rdy    = !rst && can_key && !(bus.data_in_valid && can_data && last_grant_q == TAG_KEY);
  assign data_hs    = data_rdy && bus.data_in_valid;
  assign key_hs     = key_rdy && bus.key_in_valid;

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    last_grant_d = last_grant_q;
    if (data_hs) begin
      state_d      = ST_DATA_ISSUE;
      col_d        = 2'd0;
      last_grant_d = TAG_DATA;
    end else if (key_hs) begin
      state_d      = ST_KEY_ISSUE;
      col_d        = 2'd0;
      last_grant_d = TAG_KEY;
    end else if (state_q == ST_DATA_ISSUE && col_q != LAST_COL) begin
      col_d = col_q + 2'd1;
    end else if (last_issue) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      col_q        <= 2'd0;
      last_grant_q <= TAG_KEY;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_hold_q <= '0;
      key_hold_q  <= '0;
      s4_in_q     <= '0;
      iss_q       <= '0;
      tag_pipe_q  <= '0;
    end else begin
      if (data_hs) data_hold_q <= bus.data_in;
      if (key_hs)  key_hold_q  <= bus.key_in;
      s4_in_q       <= s4_in_d;
      iss_q         <= iss_d;
      tag_pipe_q[0] <= iss_q;
      for (int i = 1; i < SBOX_LAT; i++) tag_pipe_q[i] <= tag_pipe_q[i-1];
    end
  end

  assign tail = tag_pipe_q[SBOX_LAT-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_q       <= '0;
      data_out_valid_q <= 1'b0;
      key_out_q        <= '0;
      key_out_valid_q  <= 1'b0;
    end else begin
      if (tail.vld && tail.typ == TAG_DATA) begin
        data_out_q[col_slot(tail.col)] <= s4_out;
        if (tail.col == LAST_COL) data_out_valid_q <= 1'b1;
      end else if (bus.data_out_ready) begin
        data_out_valid_q <= 1'b0;
      end
      if (tail.vld && tail.typ == TAG_KEY) begin
        key_out_q       <= s4_out;
        key_out_valid_q <= 1'b1;
      end else if (bus.key_out_ready) begin
        key_out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.data_in_ready  = data_rdy;
  assign bus.key_in_ready   = key_rdy;
  assign bus.data_out       = data_out_q;
  assign bus.data_out_valid = data_out_valid_q;
  assign bus.key_out        = key_out_q;
  assign bus.key_out_valid  = key_out_valid_q;
  assign bus.busy           = state_q != ST_IDLE || pipe_busy;
endmodule
